// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   NREQ    : number of requesters competing for the mux channel
//   state_t : arbiter FSM encoding (IDLE = no grant, GRANT = one lane owns the mux)
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// DW-wide 4:1 data mux used by the arbiter to present the granted lane.
// Ports:
//   data_in  : four packed lanes, lane i = data_in[i*DW +: DW]
//   sel      : lane index
//   data_out : selected lane (combinational)
module mux4_w #(
  parameter int DW = 8
) (
  input  logic [4*DW-1:0] data_in,
  input  logic [1:0]      sel,
  output logic [DW-1:0]   data_out
);

  always_comb begin
    data_out = data_in[0 +: DW];
    case (sel)
      2'd0:    data_out = data_in[0    +: DW];
      2'd1:    data_out = data_in[DW   +: DW];
      2'd2:    data_out = data_in[2*DW +: DW];
      2'd3:    data_out = data_in[3*DW +: DW];
      default: data_out = data_in[0    +: DW];
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select driver for a shared 4:1 mux channel.
// One requester owns the channel at a time for at most MAX_HOLD consecutive
// cycles; on release the next requester after the last winner is granted on
// the same edge, so back-to-back requesters see no idle bubble.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : level-sensitive request per requester
//   data_in   : four packed DW-wide lanes
//   gnt       : registered one-hot grant, 0 when idle
//   sel       : registered mux select, index of the gnt bit
//   data_out  : lane chosen by sel
//   out_valid : a grant is active and its requester still asserts req
//   busy      : FSM is in GRANT
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | no grant; sel parked at its last value
// ST_GRANT | gnt/sel own the channel, hold counter running
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data_in,
  output logic [NREQ-1:0]      gnt,
  output logic [1:0]           sel,
  output logic [DW-1:0]        data_out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int            HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [2:0]      pick;
  logic            rel;

  // Returns {found, index}: first set request scanning ptr+1 .. ptr+4 (mod 4).
  // The last candidate is ptr itself, so the previous winner only wins again
  // when nobody else is asking.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [1:0]      p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= NREQ; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    // A dropped req[sel] is already 0, so the search needs no extra masking.
    pick = rr_pick(req, ptr_q);
    rel  = !req[sel_q] || (hold_q == HOLD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (pick[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
          ptr_d   = pick[1:0];
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!rel) begin
          hold_d = hold_q + 1'b1;
        end else if (pick[2]) begin
          gnt_d  = 4'b0001 << pick[1:0];
          sel_d  = pick[1:0];
          ptr_d  = pick[1:0];
          hold_d = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  mux4_w #(.DW(DW)) u_mux (
    .data_in  (data_in),
    .sel      (sel_q),
    .data_out (data_out)
  );

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = (gnt_q != '0) && req[sel_q];
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] r, logic [3:0] g, logic [1:0] s,
                              logic v, logic b, logic [7:0] d);
    vec_t x;
    x.req = r; x.gnt = g; x.sel = s; x.valid = v; x.busy = b; x.dout = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic b, input logic [7:0] d);
    chk({tag, " gnt"},       32'(gnt),       32'(g));
    chk({tag, " sel"},       32'(sel),       32'(s));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " data_out"},  32'(data_out),  32'(d));
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] ei;
    bit         seen;

    // lane3=44, lane2=A5, lane1=22, lane0=11
    data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
    req     = 4'b0000;
    rst_n   = 1'b0;

    // idle traffic
    for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11));
    // single requester 2 for two cycles, then dropped; sel parks at 2
    vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5));
    vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5));
    // sole requester 0: grant re-issued after each hold expiry, never drops
    for (int i = 0; i < 9; i++) vecs.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h11));
    // hand-off to 1, then drop 1 / raise 3 on the same edge -> straight to 3
    vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h22));
    vecs.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h44));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h44));

    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      req = vecs[i].req;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid,
              vecs[i].busy, vecs[i].dout);
    end

    // asynchronous reset in the middle of a grant to requester 2
    @(negedge clk);
    req  = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (gnt == 4'b0100) seen = 1'b1;
    end
    chk("wait gnt2", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h11);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'b0010, 2'd1, 1'b1, 1'b1, 8'h22);

    // four continuous requesters from reset: each served 4 cycles in order
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #1;
      ei = 2'((k / 4) % 4);
      eg = 4'b0001 << ei;
      chk($sformatf("rr%0d gnt", k),  32'(gnt),  32'(eg));
      chk($sformatf("rr%0d sel", k),  32'(sel),  32'(ei));
      chk($sformatf("rr%0d busy", k), 32'(busy), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
